regwrite_trace_buffer: RTL

Synthesizable trace collector that sits directly downstream of the core's register-file write port. It captures every architectural register write (rd ≠ 0) into a small FIFO and streams the records out over a valid/ready port. It stops capture when the decode-stage instruction is EBREAK, drains, then emits one terminal record carrying the drop count. This gives silicon/FPGA builds the same write-trace stream the simulation dump flow produces, without hierarchical probing.

---
 rtl/regwrite_trace_buffer.sv | 64 ++++++
 1 files changed

// File: rtl/regwrite_trace_buffer.sv
// regwrite_trace_buffer: FIFO trace of register-file writes, ended by EBREAK with a drop-count terminal record.
module regwrite_trace_buffer #(
  parameter int          DEPTH_LOG2  = 3,
  parameter logic [31:0] EBREAK_WORD = 32'h00100073,
  parameter int          CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [4:0]            wr_rd,
  input  logic [31:0]           wr_data,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic                  trace_kind,
  output logic [4:0]            trace_rd,
  output logic [31:0]           trace_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  done
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_TERM, S_DONE} state_t;
  state_t                state;
  logic [36:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [DEPTH_LOG2:0]   level;
  logic [36:0]           head;
  logic                  empty, full, pop, cap, push;
  assign empty = level == '0;
  assign full  = level == (DEPTH_LOG2+1)'(DEPTH);
  assign pop   = !empty && trace_ready;
  assign cap   = state == S_RUN && wr_en && wr_rd != '0;
  assign push  = cap && (!full || pop);
  assign head  = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= {wr_rd, wr_data};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= S_RUN;
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      drop_count <= '0;
    end else begin
      if (push) wp <= wp + DEPTH_LOG2'(1);
      if (pop) rp <= rp + DEPTH_LOG2'(1);
      level <= level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
      if (cap && full && !pop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      case (state)
        S_RUN:   if (instr_valid && instr == EBREAK_WORD) state <= S_DRAIN;
        S_DRAIN: if (empty) state <= S_TERM;
        S_TERM:  if (trace_ready) state <= S_DONE;
        default: state <= S_DONE;
      endcase
    end
  assign trace_valid = !empty || state == S_TERM;
  assign trace_kind  = empty && state == S_TERM;
  assign trace_rd    = empty ? '0 : head[36:32];
  assign trace_data  = empty ? (state == S_TERM ? 32'(drop_count) : '0) : head[31:0];
  assign fifo_level  = level;
  assign done        = state == S_DONE;
endmodule
